// File: rtl/csla_pkg.sv
// csla_pkg: shared defaults and helpers for the carry-select subtractor.
// Stage count and the signed-overflow rule live here so every file agrees.
package csla_pkg;

    localparam int CSLA_WIDTH = 16;
    localparam int CSLA_BLOCK = 4;

    function automatic int csla_nblk(input int width, input int block);
        if (block < 1) begin
            return 1;
        end
        return width / block;
    endfunction

    function automatic logic csla_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/csla_sub_pipe_if.sv
// csla_sub_pipe_if: operand and result handshakes of the pipelined subtractor.
// master drives operands and out_ready; slave is the pipeline itself.
interface csla_sub_pipe_if
    import csla_pkg::*;
#(
    parameter int WIDTH = CSLA_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid,
        output a,
        output b,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  bout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output bout,
        output ovf
    );

endinterface

// File: rtl/csla_sub_slice.sv
// csla_sub_slice: one BLOCK-bit slice of a + ~b, computed for both carry-ins.
// carry_sel picks the candidate once the lower slice's carry is known.
module csla_sub_slice
    import csla_pkg::*;
#(
    parameter int BLOCK = CSLA_BLOCK
) (
    input  logic [BLOCK-1:0] a_s,
    input  logic [BLOCK-1:0] b_s,
    input  logic             carry_sel,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0] cand0;
    logic [BLOCK:0] cand1;

    always_comb begin
        cand0 = {1'b0, a_s} + {1'b0, ~b_s};
        cand1 = {1'b0, a_s} + {1'b0, ~b_s} + {{BLOCK{1'b0}}, 1'b1};
    end

    always_comb begin
        sum  = cand0[BLOCK-1:0];
        cout = cand0[BLOCK];
        unique case (carry_sel)
            1'b1: begin
                sum  = cand1[BLOCK-1:0];
                cout = cand1[BLOCK];
            end
            default: begin
                sum  = cand0[BLOCK-1:0];
                cout = cand0[BLOCK];
            end
        endcase
    end

endmodule

// File: rtl/csla_sub_pipe.sv
// csla_sub_pipe: pipelined carry-select subtractor, diff = a - b - bin.
// Stage k resolves slice k; the borrow travels between stages as a registered carry.
module csla_sub_pipe
    import csla_pkg::*;
#(
    parameter int WIDTH = CSLA_WIDTH,
    parameter int BLOCK = CSLA_BLOCK
) (
    input logic            clk,
    input logic            rst,
    csla_sub_pipe_if.slave io
);

    localparam int NBLK = csla_nblk(WIDTH, BLOCK);
    localparam int LAST = NBLK - 1;
    localparam int BDIV = (BLOCK < 1) ? 1 : BLOCK;

    if (BLOCK < 1 || (WIDTH % BDIV) != 0) begin : g_bad_cfg
        $fatal(1, "csla_sub_pipe: WIDTH must be a positive multiple of BLOCK");
    end

    logic advance;

    assign advance     = !io.out_valid || io.out_ready;
    assign io.in_ready = advance;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [BLOCK-1:0]       a_s;
        logic [BLOCK-1:0]       b_s;
        logic [BLOCK-1:0]       sum;
        logic                   cin;
        logic                   cout;
        logic                   vld_in;
        logic                   vld_q;
        logic                   vld_d;
        logic [(k+1)*BLOCK-1:0] d_nx;
        logic [(k+1)*BLOCK-1:0] d_q;
        logic [(k+1)*BLOCK-1:0] d_d;

        // Stage 0 works straight off the ports; later stages off their predecessor.
        if (k == 0) begin : g_src
            assign a_s    = io.a[BLOCK-1:0];
            assign b_s    = io.b[BLOCK-1:0];
            assign cin    = ~io.bin;
            assign vld_in = io.in_valid;
            assign d_nx   = sum;
        end else begin : g_src
            assign a_s    = g_stg[k-1].g_pnd.a_q[BLOCK-1:0];
            assign b_s    = g_stg[k-1].g_pnd.b_q[BLOCK-1:0];
            assign cin    = g_stg[k-1].g_pnd.cy_q;
            assign vld_in = g_stg[k-1].vld_q;
            assign d_nx   = {sum, g_stg[k-1].d_q};
        end

        csla_sub_slice #(
            .BLOCK(BLOCK)
        ) u_slice (
            .a_s      (a_s),
            .b_s      (b_s),
            .carry_sel(cin),
            .sum      (sum),
            .cout     (cout)
        );

        always_comb begin
            vld_d = vld_q;
            d_d   = d_q;
            if (advance) begin
                vld_d = vld_in;
                d_d   = d_nx;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                d_q   <= '0;
            end else begin
                vld_q <= vld_d;
                d_q   <= d_d;
            end
        end

        if (k < LAST) begin : g_pnd
            localparam int WP = WIDTH - (k + 1) * BLOCK;

            logic [WP-1:0] a_nx;
            logic [WP-1:0] b_nx;
            logic [WP-1:0] a_q;
            logic [WP-1:0] a_d;
            logic [WP-1:0] b_q;
            logic [WP-1:0] b_d;
            logic          cy_q;
            logic          cy_d;

            // Only the operand bits above this slice travel on.
            if (k == 0) begin : g_nx
                assign a_nx = io.a[WIDTH-1:BLOCK];
                assign b_nx = io.b[WIDTH-1:BLOCK];
            end else begin : g_nx
                assign a_nx = g_stg[k-1].g_pnd.a_q[WP+BLOCK-1:BLOCK];
                assign b_nx = g_stg[k-1].g_pnd.b_q[WP+BLOCK-1:BLOCK];
            end

            always_comb begin
                a_d  = a_q;
                b_d  = b_q;
                cy_d = cy_q;
                if (advance) begin
                    a_d  = a_nx;
                    b_d  = b_nx;
                    cy_d = cout;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    cy_q <= 1'b0;
                end else begin
                    a_q  <= a_d;
                    b_q  <= b_d;
                    cy_q <= cy_d;
                end
            end
        end else begin : g_out
            logic bout_q;
            logic bout_d;
            logic ovf_q;
            logic ovf_d;

            // The top slice sees the operand MSBs, so flags resolve here.
            always_comb begin
                bout_d = bout_q;
                ovf_d  = ovf_q;
                if (advance) begin
                    bout_d = ~cout;
                    ovf_d  = csla_ovf(a_s[BLOCK-1], b_s[BLOCK-1], sum[BLOCK-1]);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else begin
                    bout_q <= bout_d;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end

    assign io.out_valid = g_stg[LAST].vld_q;
    assign io.diff      = g_stg[LAST].d_q;
    assign io.bout      = g_stg[LAST].g_out.bout_q;
    assign io.ovf       = g_stg[LAST].g_out.ovf_q;

endmodule

// File: tb/tb_csla_sub_pipe.sv
// tb_csla_sub_pipe: scoreboard bench for the pipelined carry-select subtractor.
// Driver pushes expected results on accept; a negedge monitor compares outputs.
module tb_csla_sub_pipe;
    import csla_pkg::*;

    localparam int W  = CSLA_WIDTH;
    localparam int NB = CSLA_WIDTH / CSLA_BLOCK;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   rnd_done = 1'b0;
    exp_t sb[$];

    csla_sub_pipe_if #(.WIDTH(W)) bus ();

    csla_sub_pipe #(
        .WIDTH(W),
        .BLOCK(CSLA_BLOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        logic [W:0] full;
        int         s;
        exp_t       e;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        s    = int'($signed(ma)) - int'($signed(mb)) - (mbin ? 1 : 0);
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (s > 32767) || (s < -32768);
        return e;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
        int n = 0;
        bus.a        = ta;
        bus.b        = tb;
        bus.bin      = tbin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) begin
            sb.push_back('{ed, eb, eo});
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic lat_check(input string nm);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, n, NB - 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Compares against the queue head every cycle a result is shown, so held
    // results are checked for stability and popped only on the handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", bus.diff, 32'hdead_beef);
            end else begin
                chk("diff", bus.diff, sb[0].d);
                chk("bout", bus.bout, sb[0].bo);
                chk("ovf", bus.ovf, sb[0].ov);
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        chk("rst_ovf", bus.ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);

        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        lat_check("latency_first");
        drain();

        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        fork
            begin
                send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);
                send(16'h0100, 16'h0010, 1'b0, 16'h00F0, 1'b0, 1'b0);
                send(16'h1000, 16'h0100, 1'b0, 16'h0F00, 1'b0, 1'b0);
                send(16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0);
                send(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0);
                send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
            end
            begin
                int n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", bus.in_ready, 0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0);
        send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0);
        send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0);
        send(16'h4444, 16'h0004, 1'b0, 16'h4440, 1'b0, 1'b0);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_diff", bus.diff, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 1);
        send(16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0);
        lat_check("latency_after_rst");
        drain();

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    ra   = W'($urandom);
                    rb   = W'($urandom);
                    rbin = 1'($urandom_range(0, 1));
                    e    = model(ra, rb, rbin);
                    send(ra, rb, rbin, e.d, e.bo, e.ov);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csla_sub_pipe.md
Name: csla_sub_pipe

Overview:
- Pipelined, parameterised carry-select subtractor: computes diff = a - b - bin.
- Operand width is split into BLOCK-bit slices; one pipeline stage per slice.
- Each stage precomputes both candidate results (borrow-in 0 and borrow-in 1), then selects using the registered borrow from the previous stage.
- Valid/ready handshake on both sides; sits in the datapath lab alongside the adder blocks as their subtraction counterpart.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 4, slice width in bits; the number of stages is NBLK = WIDTH/BLOCK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 when the unsigned value a < b + bin.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic: diff = a + ~b + ~bin; carry into slice 0 = ~bin; bout = ~(carry out of the top slice).
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- Stage k (k = 0..NBLK-1):
  - Computes slice k twice: once with carry-in 0 and once with carry-in 1.
  - Muxes both sum and carry using the carry registered by stage k-1. Stage 0 uses ~bin.
  - Registers: the selected slice, all lower slices already computed, the raw a/b upper slices still pending, the carry, and a per-stage valid bit.
- Latency: an operand accepted at edge N appears on out_valid/diff after edge N+NBLK−1. Example: NBLK=4 gives 3 further edges, so the result is visible in the 4th cycle after acceptance.
- Throughput: one result per cycle when out_ready stays high.
- Flow control:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - On advance, every stage shifts by one and stage 0 loads {in_valid, operands}.
  - When !advance, all stages hold, including bubbles.
  - An accept occurs only on in_valid && in_ready.
- Bubbles: a stage whose valid bit is 0 still shifts, but its data is don't-care. Output ports are driven from the last stage register.
- Hold: while out_valid && !out_ready, diff/bout/ovf stay stable.
- Reset: on rst assertion, all valid bits, diff, bout and ovf clear to 0 immediately. In-flight operations are discarded. in_ready = 1 once reset is released.
- Boundaries:
  - An all-ones borrow chain (e.g. 0 - 1) must propagate through every stage with no extra latency.
  - With bin=1 and a==b, the result is all-ones and bout=1.
  - A full pipeline with out_ready low accepts no new operand and loses no data.
  - An accept and a drain in the same cycle are legal and keep ordering.
- Elaboration check: WIDTH % BLOCK != 0 or BLOCK < 1 is a fatal elaboration error.

Decomposition:
- Package csla_pkg: default WIDTH/BLOCK constants and a function computing NBLK.
- Sub-module csla_sub_slice: combinational BLOCK-bit dual-candidate add of a_slice + ~b_slice with carry-in 0 and 1, plus a select mux on carry_sel. Outputs are the selected slice sum and carry.
- Top level: generates NBLK slices and the pipeline registers.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> diff=0x1000, bout=0, ovf=0; out_valid rises exactly NBLK-1 edges after the accepting edge.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0 (borrow through all 4 slices). Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
- a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Backpressure: stream 6 back-to-back ops and hold out_ready=0 for 5 cycles after the first result. Expect in_ready=0 while the pipe is full, diff held stable, then all 6 results in order with no duplicates.
- Reset mid-stream: assert rst between edges with 3 ops in flight. Expect out_valid=0, diff=0 before the next edge; after release, a fresh op returns the correct result with nominal latency.
- Random: 10k random a/b/bin values with random in_valid/out_ready, checked against a reference model for diff/bout/ovf and ordering.
